scope_trigger_ctrl: RTL and testbench

Upstream stage of the scope capture shift register. It watches the 3-bit probed signal and waits for a programmable trigger edge. On trigger it drives capture_enable high for exactly SAMPLE_COUNT clocks, so the downstream register holds one clean trigger-aligned window. It then freezes for a holdoff period, and either re-arms automatically or waits for a software arm (single-shot).

---
 rtl/scope_pkg.sv | 21 ++
 rtl/scope_edge_detect.sv | 42 ++++
 rtl/scope_trigger_ctrl.sv | 100 ++++++++++
 tb/tb_scope_trigger_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared definitions for the scope trigger controller and its capture stage.
package scope_pkg;

  localparam int unsigned SCOPE_BITS = 16;
  localparam int unsigned SIGNAL_W   = 3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StHold    = 2'd3
  } scope_state_e;

  typedef enum logic [1:0] {
    TrigBit0 = 2'd0,
    TrigBit1 = 2'd1,
    TrigBit2 = 2'd2,
    TrigAny  = 2'd3
  } trig_sel_e;

endpackage

// File: rtl/scope_edge_detect.sv
// Edge detector on the probed bus: registers the previous sample and flags the
// selected edge combinationally.
module scope_edge_detect
  import scope_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [SIGNAL_W-1:0] the_signal,
  input  logic [1:0]          trig_sel,
  input  logic                trig_pol,
  output logic                trig_event
);

  logic [SIGNAL_W-1:0] prev_sig_q;
  logic [SIGNAL_W-1:0] rise;
  logic [SIGNAL_W-1:0] fall;
  logic [SIGNAL_W-1:0] edge_vec;

  // Tracks in every state so an edge on the first armed cycle is seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_sig_q <= '0;
    end else begin
      prev_sig_q <= the_signal;
    end
  end

  always_comb begin
    rise       = the_signal & ~prev_sig_q;
    fall       = ~the_signal & prev_sig_q;
    edge_vec   = trig_pol ? rise : fall;
    trig_event = 1'b0;
    unique case (trig_sel)
      TrigBit0: trig_event = edge_vec[0];
      TrigBit1: trig_event = edge_vec[1];
      TrigBit2: trig_event = edge_vec[2];
      TrigAny:  trig_event = |(the_signal ^ prev_sig_q);
      default:  trig_event = 1'b0;
    endcase
  end

endmodule

// File: rtl/scope_trigger_ctrl.sv
// Trigger controller: arms, waits for an edge, opens a fixed-length capture
// window, then holds off before re-arming or returning to idle.
module scope_trigger_ctrl
  import scope_pkg::*;
#(
  parameter int unsigned SAMPLE_COUNT   = 5,
  parameter int unsigned HOLDOFF_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SIGNAL_W-1:0] the_signal,
  input  logic [1:0]          trig_sel,
  input  logic                trig_pol,
  input  logic                trig_mode,
  input  logic                arm,
  input  logic                force_trig,
  output logic                capture_enable,
  output logic                capture_done,
  output logic [1:0]          state_o,
  output logic [7:0]          sample_idx
);

  localparam logic [7:0] SampleLast = 8'(SAMPLE_COUNT);
  // A zero holdoff still spends one clock in HOLD.
  localparam logic [CNT_W-1:0] HoldLast =
      (HOLDOFF_CYCLES == 0) ? '0 : CNT_W'(HOLDOFF_CYCLES - 1);

  scope_state_e     state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             cap_en_q;
  logic             cap_done_q;
  logic             trig_event;

  scope_edge_detect u_edge_detect (
    .clk        (clk),
    .reset      (reset),
    .the_signal (the_signal),
    .trig_sel   (trig_sel),
    .trig_pol   (trig_pol),
    .trig_event (trig_event)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (arm || trig_mode) state_d = StArmed;
      end
      StArmed: begin
        if (trig_event || force_trig) begin
          state_d = StCapture;
          idx_d   = 8'd1;
        end
      end
      StCapture: begin
        if (idx_q >= SampleLast) begin
          state_d    = StHold;
          hold_cnt_d = '0;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      StHold: begin
        if (hold_cnt_q >= HoldLast) begin
          state_d = trig_mode ? StArmed : StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from next-state so capture_enable never glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      hold_cnt_q <= '0;
      cap_en_q   <= 1'b0;
      cap_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      cap_en_q   <= (state_d == StCapture);
      cap_done_q <= (state_q == StCapture) && (state_d == StHold);
    end
  end

  assign capture_enable = cap_en_q;
  assign capture_done   = cap_done_q;
  assign state_o        = state_q;
  assign sample_idx     = idx_q;

endmodule

// File: tb/tb_scope_trigger_ctrl.sv
// Scoreboard bench for scope_trigger_ctrl: stimulus queues the expected capture
// beats, a monitor pops one whenever capture_enable or capture_done is high.
module tb_scope_trigger_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] the_signal;
  logic [1:0] trig_sel;
  logic       trig_pol;
  logic       trig_mode;
  logic       arm;
  logic       force_trig;
  logic       capture_enable;
  logic       capture_done;
  logic [1:0] state;
  logic [7:0] sample_idx;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic       en;
    logic       done;
    logic [7:0] idx;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];

  scope_trigger_ctrl #(
    .SAMPLE_COUNT   (5),
    .HOLDOFF_CYCLES (10),
    .CNT_W          (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .the_signal     (the_signal),
    .trig_sel       (trig_sel),
    .trig_pol       (trig_pol),
    .trig_mode      (trig_mode),
    .arm            (arm),
    .force_trig     (force_trig),
    .capture_enable (capture_enable),
    .capture_done   (capture_done),
    .state_o        (state),
    .sample_idx     (sample_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to 2 time units after the posedge that starts cycle c.
  task automatic to_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic state_at(input string name, input int c, input logic [1:0] exp);
    to_cyc(c);
    @(negedge clk);
    check(name, state, exp);
  endtask

  // n enable beats starting at cycle first, then optionally the done pulse.
  task automatic push_capture(input int first, input int n, input bit with_done);
    for (int i = 1; i <= n; i++) begin
      sb.push_back('{cyc: first + i - 1, en: 1'b1, done: 1'b0, idx: 8'(i), st: 2'd2});
    end
    if (with_done) begin
      sb.push_back('{cyc: first + 5, en: 1'b0, done: 1'b1, idx: 8'd5, st: 2'd3});
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && (capture_enable !== 1'b0 || capture_done !== 1'b0)) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {30'd0, capture_enable, capture_done}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_cycle", cyc, e.cyc);
          check("capture_enable", capture_enable, e.en);
          check("capture_done", capture_done, e.done);
          check("sample_idx", sample_idx, e.idx);
          check("state_during_out", state, e.st);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stimulus
    int first, h;
    reset      = 1'b1;
    the_signal = 3'b000;
    trig_sel   = 2'd0;
    trig_pol   = 1'b1;
    trig_mode  = 1'b0;
    arm        = 1'b0;
    force_trig = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_cap_en", capture_enable, 0);
    check("rst_cap_done", capture_done, 0);
    check("rst_sample_idx", sample_idx, 0);
    to_cyc(2);
    reset = 1'b1;

    // Single-shot, never armed: stays idle even with edges and force_trig.
    for (int i = 0; i < 20; i++) begin
      force_trig = (i >= 5 && i < 9);
      the_signal = 3'(i);
      @(negedge clk);
      check("idle_state", state, 0);
      check("idle_cap_en", capture_enable, 0);
      @(posedge clk);
      #2;
    end
    force_trig = 1'b0;
    the_signal = 3'b000;
    @(posedge clk);
    #2;

    // Armed rising edge on bit 1.
    arm      = 1'b1;
    trig_sel = 2'd1;
    trig_pol = 1'b1;
    @(posedge clk);
    #2;
    arm = 1'b0;
    @(negedge clk);
    check("armed_after_arm", state, 1);
    @(posedge clk);
    #2;
    the_signal = 3'b010;
    first = cyc + 1;
    push_capture(first, 5, 1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #2;
      the_signal = i[0] ? 3'b010 : 3'b000;
    end
    h = first + 5;
    state_at("hold_last", h + 9, 3);
    check("idx_held_in_hold", sample_idx, 5);
    state_at("single_shot_idle", h + 10, 0);

    // Auto re-arm with edges during capture and hold.
    @(posedge clk);
    #2;
    trig_mode  = 1'b1;
    the_signal = 3'b000;
    to_cyc(cyc + 2);
    the_signal = 3'b010;
    first = cyc + 1;
    push_capture(first, 5, 1);
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #2;
      the_signal = i[0] ? 3'b000 : 3'b010;
    end
    h = first + 5;
    to_cyc(h + 8);
    the_signal = 3'b000;
    state_at("auto_hold_last", h + 9, 3);
    to_cyc(h + 10);
    the_signal = 3'b010;
    first = cyc + 1;
    push_capture(first, 5, 1);
    @(negedge clk);
    check("auto_rearmed", state, 1);

    // Polarity and bit-select: falling/rising mismatches must not trigger.
    h = first + 5;
    to_cyc(h + 3);
    the_signal = 3'b101;
    trig_sel   = 2'd0;
    trig_pol   = 1'b1;
    state_at("rearmed_again", h + 10, 1);
    to_cyc(h + 11);
    the_signal = 3'b100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_trig_fall_bit0", state, 1);
      @(posedge clk);
      #2;
    end
    trig_pol   = 1'b0;
    the_signal = 3'b101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_trig_rise_bit0", state, 1);
      @(posedge clk);
      #2;
    end
    trig_sel   = 2'd3;
    the_signal = 3'b100;
    first = cyc + 1;
    push_capture(first, 5, 1);
    to_cyc(first + 2);
    trig_mode = 1'b0;
    h = first + 5;
    state_at("any_hold_last", h + 9, 3);
    state_at("mode_sampled_idle", h + 10, 0);

    // force_trig together with an edge gives a single capture.
    to_cyc(h + 11);
    arm = 1'b1;
    to_cyc(cyc + 1);
    arm        = 1'b0;
    force_trig = 1'b1;
    the_signal = 3'b110;
    first = cyc + 1;
    push_capture(first, 5, 1);
    to_cyc(first);
    force_trig = 1'b0;
    h = first + 5;
    state_at("force_hold_last", h + 9, 3);
    state_at("force_idle", h + 10, 0);

    // Reset on the third capture clock.
    to_cyc(h + 11);
    arm = 1'b1;
    to_cyc(cyc + 1);
    arm        = 1'b0;
    force_trig = 1'b1;
    first = cyc + 1;
    push_capture(first, 2, 0);
    to_cyc(first);
    force_trig = 1'b0;
    to_cyc(first + 2);
    reset = 1'b0;
    #1;
    check("midrst_cap_en", capture_enable, 0);
    check("midrst_state", state, 0);
    check("midrst_sample_idx", sample_idx, 0);
    check("midrst_cap_done", capture_done, 0);
    to_cyc(first + 4);
    reset = 1'b1;
    state_at("post_rst_idle", first + 6, 0);
    to_cyc(first + 7);
    arm = 1'b1;
    to_cyc(cyc + 1);
    arm        = 1'b0;
    the_signal = 3'b010;
    first = cyc + 1;
    push_capture(first, 5, 1);
    state_at("restart_end_idle", first + 16, 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
